stdp_synapse: RTL and testbench



---
 rtl/stdp_synapse_if.sv | 24 ++
 rtl/stdp_synapse.sv | 107 ++++++++++
 tb/tb_stdp_synapse.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/stdp_synapse_if.sv
// Synapse-side bundle: learning control and spike inputs, weight/update status outputs.
interface stdp_synapse_if #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned T_WIDTH = 4
);
  logic               learn_en;
  logic               pre_spike;
  logic               post_spike;
  logic [W_WIDTH-1:0] weight;
  logic [W_WIDTH-1:0] syn_current;
  logic               update_w_flag;
  logic               ltp;
  logic [T_WIDTH-1:0] time_diff;

  modport master (
    output learn_en, pre_spike, post_spike,
    input  weight, syn_current, update_w_flag, ltp, time_diff
  );

  modport slave (
    input  learn_en, pre_spike, post_spike,
    output weight, syn_current, update_w_flag, ltp, time_diff
  );
endinterface

// File: rtl/stdp_synapse.sv
// Plastic synapse: pair-based nearest-neighbour STDP on an on-chip weight,
// plus the weighted synaptic current pulse that feeds the postsynaptic neuron.
module stdp_synapse #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned T_WIDTH = 4,
  parameter int unsigned W_INIT  = 64,
  parameter int unsigned W_MAX   = 255,
  parameter int unsigned W_MIN   = 0,
  parameter int unsigned A_PLUS  = 16,
  parameter int unsigned A_MINUS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  stdp_synapse_if.slave bus
);

  localparam logic [T_WIDTH-1:0]   TMAX      = '1;
  localparam logic [W_WIDTH-1:0]   W_INIT_W  = W_WIDTH'(W_INIT);
  localparam logic [W_WIDTH-1:0]   W_MAX_W   = W_WIDTH'(W_MAX);
  localparam logic [W_WIDTH-1:0]   W_MIN_W   = W_WIDTH'(W_MIN);
  localparam logic [W_WIDTH-1:0]   A_PLUS_W  = W_WIDTH'(A_PLUS);
  localparam logic [W_WIDTH-1:0]   A_MINUS_W = W_WIDTH'(A_MINUS);
  localparam logic [W_WIDTH:0]     W_MAX_X   = (W_WIDTH+1)'(W_MAX);
  localparam logic signed [W_WIDTH+1:0] W_MIN_S = (W_WIDTH+2)'(W_MIN);

  logic [T_WIDTH-1:0] pre_t_q,  pre_t_d;
  logic [T_WIDTH-1:0] post_t_q, post_t_d;
  logic [W_WIDTH-1:0] weight_q, weight_d;
  logic [W_WIDTH-1:0] syn_current_q, syn_current_d;
  logic               update_w_flag_q, update_w_flag_d;
  logic               ltp_q, ltp_d;
  logic [T_WIDTH-1:0] time_diff_q, time_diff_d;

  logic                      do_ltp, do_ltd;
  logic [T_WIDTH-1:0]        ltp_shift, ltd_shift;
  logic [W_WIDTH-1:0]        ltp_delta, ltd_delta;
  logic [W_WIDTH:0]          ltp_sum;
  logic signed [W_WIDTH+1:0] ltd_diff;

  // Pairing decision and step size; sampled timer + 1 is dt, so (dt-1)>>2 is timer>>2
  always_comb begin
    do_ltp    = bus.learn_en && bus.post_spike && !bus.pre_spike && (pre_t_q != TMAX);
    do_ltd    = bus.learn_en && bus.pre_spike && !bus.post_spike && (post_t_q != TMAX);
    ltp_shift = pre_t_q >> 2;
    ltd_shift = post_t_q >> 2;
    ltp_delta = A_PLUS_W >> ltp_shift;
    ltd_delta = A_MINUS_W >> ltd_shift;
    ltp_sum   = {1'b0, weight_q} + {1'b0, ltp_delta};
    ltd_diff  = $signed({2'b00, weight_q}) - $signed({2'b00, ltd_delta});
  end

  // Next-state: timers, clamped weight update and status
  always_comb begin
    pre_t_d         = pre_t_q;
    post_t_d        = post_t_q;
    weight_d        = weight_q;
    ltp_d           = ltp_q;
    time_diff_d     = time_diff_q;
    update_w_flag_d = 1'b0;
    syn_current_d   = bus.pre_spike ? weight_q : '0;

    if (bus.pre_spike)          pre_t_d = '0;
    else if (pre_t_q != TMAX)   pre_t_d = pre_t_q + T_WIDTH'(1);

    if (bus.post_spike)         post_t_d = '0;
    else if (post_t_q != TMAX)  post_t_d = post_t_q + T_WIDTH'(1);

    if (do_ltp) begin
      weight_d        = (ltp_sum > W_MAX_X) ? W_MAX_W : ltp_sum[W_WIDTH-1:0];
      ltp_d           = 1'b1;
      time_diff_d     = pre_t_q + T_WIDTH'(1);
      update_w_flag_d = 1'b1;
    end else if (do_ltd) begin
      weight_d        = (ltd_diff < W_MIN_S) ? W_MIN_W : ltd_diff[W_WIDTH-1:0];
      ltp_d           = 1'b0;
      time_diff_d     = post_t_q + T_WIDTH'(1);
      update_w_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_t_q         <= TMAX;
      post_t_q        <= TMAX;
      weight_q        <= W_INIT_W;
      syn_current_q   <= '0;
      update_w_flag_q <= 1'b0;
      ltp_q           <= 1'b0;
      time_diff_q     <= '0;
    end else begin
      pre_t_q         <= pre_t_d;
      post_t_q        <= post_t_d;
      weight_q        <= weight_d;
      syn_current_q   <= syn_current_d;
      update_w_flag_q <= update_w_flag_d;
      ltp_q           <= ltp_d;
      time_diff_q     <= time_diff_d;
    end
  end

  assign bus.weight        = weight_q;
  assign bus.syn_current   = syn_current_q;
  assign bus.update_w_flag = update_w_flag_q;
  assign bus.ltp           = ltp_q;
  assign bus.time_diff     = time_diff_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse: pairing windows, step sizes, clamps,
// simultaneous spikes, frozen learning and asynchronous reset.
module tb_stdp_synapse;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  stdp_synapse_if #(.W_WIDTH(8), .T_WIDTH(4)) bus ();

  stdp_synapse #(
    .W_WIDTH(8), .T_WIDTH(4), .W_INIT(64), .W_MAX(255), .W_MIN(0),
    .A_PLUS(16), .A_MINUS(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given spikes; returns at the next falling edge
  task automatic cyc(input logic pre, input logic post);
    bus.pre_spike  = pre;
    bus.post_spike = post;
    @(negedge clk);
    bus.pre_spike  = 1'b0;
    bus.post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.learn_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pre (learning off so it cannot depress) then post d cycles later: LTP with dt=d
  task automatic ltp_pair(input int d);
    bus.learn_en = 1'b0;
    cyc(1'b1, 1'b0);
    bus.learn_en = 1'b1;
    idle(d - 1);
    cyc(1'b0, 1'b1);
  endtask

  task automatic ltd_pair(input int d);
    bus.learn_en = 1'b0;
    cyc(1'b0, 1'b1);
    bus.learn_en = 1'b1;
    idle(d - 1);
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.learn_en = 1'b0;
    bus.pre_spike = 1'b0;
    bus.post_spike = 1'b0;

    // Reset state
    do_reset();
    check("rst_weight", 32'(bus.weight), 64);
    check("rst_syn", 32'(bus.syn_current), 0);
    check("rst_flag", 32'(bus.update_w_flag), 0);
    check("rst_ltp", 32'(bus.ltp), 0);
    check("rst_td", 32'(bus.time_diff), 0);

    // Pre at 0, post at 3 -> dt=3, +16
    cyc(1'b1, 1'b0);
    check("s1_syn", 32'(bus.syn_current), 64);
    check("s1_flag0", 32'(bus.update_w_flag), 0);
    cyc(1'b0, 1'b0);
    check("s1_syn_pulse", 32'(bus.syn_current), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("s1_weight", 32'(bus.weight), 80);
    check("s1_flag", 32'(bus.update_w_flag), 1);
    check("s1_ltp", 32'(bus.ltp), 1);
    check("s1_td", 32'(bus.time_diff), 3);
    cyc(1'b0, 1'b0);
    check("s1_flag_pulse", 32'(bus.update_w_flag), 0);
    check("s1_weight_hold", 32'(bus.weight), 80);

    // Post at 0, pre at 6 -> dt=6, -8; current uses pre-update weight
    do_reset();
    cyc(1'b0, 1'b1);
    idle(5);
    cyc(1'b1, 1'b0);
    check("s2_weight", 32'(bus.weight), 56);
    check("s2_syn", 32'(bus.syn_current), 64);
    check("s2_ltp", 32'(bus.ltp), 0);
    check("s2_td", 32'(bus.time_diff), 6);
    check("s2_flag", 32'(bus.update_w_flag), 1);

    // Pre at 0, post at 20 -> timer saturated, no update
    do_reset();
    cyc(1'b1, 1'b0);
    for (int i = 1; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 15) check("s3_flag_idle", 32'(bus.update_w_flag), 0);
    end
    cyc(1'b0, 1'b1);
    check("s3_flag", 32'(bus.update_w_flag), 0);
    check("s3_weight", 32'(bus.weight), 64);
    // That post is cycle 0; pre at 14 -> dt=14, -2
    idle(13);
    cyc(1'b1, 1'b0);
    check("s3_ltd14_weight", 32'(bus.weight), 62);
    check("s3_ltd14_td", 32'(bus.time_diff), 14);

    // Build weight to 250, then LTP dt=2 clamps at 255
    do_reset();
    for (int i = 0; i < 11; i++) ltp_pair(1);
    check("s4_w240", 32'(bus.weight), 240);
    ltp_pair(5);
    check("s4_w248", 32'(bus.weight), 248);
    ltp_pair(13);
    check("s4_w250", 32'(bus.weight), 250);
    ltp_pair(2);
    check("s4_clamp_hi", 32'(bus.weight), 255);
    check("s4_clamp_hi_flag", 32'(bus.update_w_flag), 1);
    ltp_pair(1);
    check("s4_sat_flag", 32'(bus.update_w_flag), 1);
    check("s4_sat_weight", 32'(bus.weight), 255);

    // Bring weight to 6, then LTD dt=1 clamps at 0
    do_reset();
    for (int i = 0; i < 3; i++) ltd_pair(1);
    ltd_pair(5);
    ltd_pair(13);
    check("s5_w6", 32'(bus.weight), 6);
    ltd_pair(1);
    check("s5_clamp_lo", 32'(bus.weight), 0);
    check("s5_clamp_lo_flag", 32'(bus.update_w_flag), 1);
    ltd_pair(1);
    check("s5_sat_flag", 32'(bus.update_w_flag), 1);
    check("s5_sat_weight", 32'(bus.weight), 0);

    // Simultaneous spikes at 10, post at 12 -> dt=2, +16
    do_reset();
    idle(10);
    cyc(1'b1, 1'b1);
    check("s6_sim_flag", 32'(bus.update_w_flag), 0);
    check("s6_sim_weight", 32'(bus.weight), 64);
    check("s6_sim_syn", 32'(bus.syn_current), 64);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("s6_weight", 32'(bus.weight), 80);
    check("s6_td", 32'(bus.time_diff), 2);

    // Learning frozen: timers and current run, weight holds
    do_reset();
    bus.learn_en = 1'b0;
    cyc(1'b1, 1'b0);
    check("s7_syn", 32'(bus.syn_current), 64);
    idle(2);
    cyc(1'b0, 1'b1);
    check("s7_flag", 32'(bus.update_w_flag), 0);
    check("s7_weight", 32'(bus.weight), 64);
    check("s7_ltp", 32'(bus.ltp), 0);
    check("s7_td", 32'(bus.time_diff), 0);

    // Async reset between pre at 0 and post at 3
    do_reset();
    ltp_pair(3);
    check("s8_pre_w", 32'(bus.weight), 80);
    bus.learn_en = 1'b0;
    cyc(1'b1, 1'b0);
    bus.learn_en = 1'b1;
    check("s8_syn", 32'(bus.syn_current), 80);
    #2 rst_n = 1'b0;
    #1;
    check("s8_async_weight", 32'(bus.weight), 64);
    check("s8_async_syn", 32'(bus.syn_current), 0);
    check("s8_async_ltp", 32'(bus.ltp), 0);
    check("s8_async_td", 32'(bus.time_diff), 0);
    check("s8_async_flag", 32'(bus.update_w_flag), 0);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("s8_post_flag", 32'(bus.update_w_flag), 0);
    check("s8_post_weight", 32'(bus.weight), 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
